// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated circular transmit FIFO and configurable frame format.
// Optional line-break input (port brk) is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned CLK_PER_BIT = 60,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
`ifdef UART_TX_BREAK_EN
  input  logic                        brk,
`endif
  output logic                        txd,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CYC_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 push_c;
  logic                 pop_c;
  logic [DATA_BITS-1:0] head_c;

  // Serializer state
  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 bit_end_c;
  logic                 can_pop_c;

`ifdef UART_TX_BREAK_EN
  logic                 recover_q, recover_d;
`endif

  assign tx_ready   = (count_q != CNT_FULL);
  assign push_c     = tx_valid && tx_ready;
  assign head_c     = mem_q[rd_ptr_q];
  assign bit_end_c  = (cyc_q == CYC_LAST);
  assign txd        = txd_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE) || (count_q != '0);

  // A held break blocks the pop that would otherwise chain the next frame.
`ifdef UART_TX_BREAK_EN
  assign can_pop_c = (count_q != '0) && !brk;
`else
  assign can_pop_c = (count_q != '0);
`endif

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Serializer next state; a pop loads the head entry and starts the start bit
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    pop_c   = 1'b0;
`ifdef UART_TX_BREAK_EN
    recover_d = recover_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk) begin
          txd_d     = 1'b0;
          recover_d = 1'b1;
          cyc_d     = '0;
        end else if (recover_q) begin
          // one full bit period of mark after a break before any frame
          txd_d = 1'b1;
          if (bit_end_c) begin
            recover_d = 1'b0;
            cyc_d     = '0;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end else
`endif
        if (can_pop_c) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          par_d   = (PARITY == 2) ? ^head_c : ~^head_c;
          txd_d   = 1'b0;
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end_c) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end_c) begin
          cyc_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              txd_d   = par_q;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end_c) begin
          txd_d   = 1'b1;
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end_c) begin
          cyc_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (can_pop_c) begin
              pop_c   = 1'b1;
              shift_d = head_c;
              par_d   = (PARITY == 2) ? ^head_c : ~^head_c;
              txd_d   = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage has no reset; the pointers and count define validity
  always_ff @(posedge clock) begin
    if (!reset && push_c) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
`ifdef UART_TX_BREAK_EN
      recover_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
`ifdef UART_TX_BREAK_EN
      recover_q <= recover_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats side by side, each checked every cycle
// against a queue-based line model, plus directed frames with hand-derived waveforms.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int NI = 3;
  // instance 0: 8N1 depth 4; instance 1: 7O2 depth 8; instance 2: 8E1 depth 16
  localparam logic [NI-1:0][7:0] CPB_T = {8'd5,  8'd3, 8'd4};
  localparam logic [NI-1:0][7:0] DB_T  = {8'd8,  8'd7, 8'd8};
  localparam logic [NI-1:0][7:0] PAR_T = {8'd2,  8'd1, 8'd0};
  localparam logic [NI-1:0][7:0] STP_T = {8'd1,  8'd2, 8'd1};
  localparam logic [NI-1:0][7:0] DEP_T = {8'd16, 8'd8, 8'd4};

  logic       clock     = 1'b0;
  logic       reset     = 1'b1;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data_v = 8'h00;
  logic       checking  = 1'b0;
  int         n_tests   = 0;
  int         n_fail    = 0;

  logic txd_w   [NI];
  logic ready_w [NI];
  logic busy_w  [NI];
  int   count_w [NI];

  always #5 clock = ~clock;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned CPB = int'(CPB_T[g]);
    localparam int unsigned DB  = int'(DB_T[g]);
    localparam int unsigned PAR = int'(PAR_T[g]);
    localparam int unsigned STP = int'(STP_T[g]);
    localparam int unsigned DEP = int'(DEP_T[g]);
    localparam int unsigned CW  = $clog2(DEP) + 1;

    logic          txd, ready, busy;
    logic [CW-1:0] cnt;

    uart_tx_fifo #(
      .CLK_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(STP), .FIFO_DEPTH(DEP)
    ) dut (
      .clock      (clock),
      .reset      (reset),
`ifdef UART_TX_BREAK_EN
      .brk        (1'b0),
`endif
      .txd        (txd),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data_v[DB-1:0]),
      .tx_ready   (ready),
      .tx_busy    (busy),
      .fifo_count (cnt)
    );

    assign txd_w[g]   = txd;
    assign ready_w[g] = ready;
    assign busy_w[g]  = busy;
    assign count_w[g] = int'(cnt);

    // Line model: a queue of pending bytes and a queue of per-cycle txd samples.
    int fifo_m[$];
    bit line_m[$];
    bit exp_txd  = 1'b1;
    bit exp_busy = 1'b0;

    always @(posedge clock) begin
      bit push_ok;
      bit took;
      bit p;
      int d;
      if (reset) begin
        fifo_m.delete();
        line_m.delete();
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
      end else begin
        push_ok = tx_valid && (fifo_m.size() != int'(DEP));
        if (line_m.size() == 0 && fifo_m.size() != 0) begin
          d = fifo_m.pop_front();
          p = (PAR == 2) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0);
          for (int i = 0; i < int'(CPB); i++) line_m.push_back(1'b0);
          for (int b = 0; b < int'(DB); b++)
            for (int i = 0; i < int'(CPB); i++) line_m.push_back(d[b]);
          if (PAR != 0)
            for (int i = 0; i < int'(CPB); i++) line_m.push_back(p);
          for (int i = 0; i < int'(STP * CPB); i++) line_m.push_back(1'b1);
        end
        took    = (line_m.size() != 0);
        exp_txd = took ? line_m.pop_front() : 1'b1;
        if (push_ok) fifo_m.push_back(int'(tx_data_v) & ((1 << DB) - 1));
        exp_busy = took || (fifo_m.size() != 0);
      end
    end

    always @(negedge clock) begin
      if (checking) begin
        chk($sformatf("i%0d txd", g),        int'(txd),   int'(exp_txd));
        chk($sformatf("i%0d tx_ready", g),   int'(ready), int'(fifo_m.size() != int'(DEP)));
        chk($sformatf("i%0d tx_busy", g),    int'(busy),  int'(exp_busy));
        chk($sformatf("i%0d fifo_count", g), int'(cnt),   fifo_m.size());
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Push one byte into an empty FIFO and compare instance g's line against a literal frame.
  task automatic frame_literal(input int g, input logic [7:0] d, input logic [11:0] frame,
                               input int nbits);
    int cpb;
    cpb = int'(CPB_T[g]);
    pulse_reset();
    tx_data_v = d;
    tx_valid  = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    chk($sformatf("i%0d lit count after push", g), count_w[g], 1);
    chk($sformatf("i%0d lit busy after push", g), int'(busy_w[g]), 1);
    chk($sformatf("i%0d lit txd at push edge", g), int'(txd_w[g]), 1);
    for (int k = 1; k <= nbits * cpb; k++) begin
      @(negedge clock);
      chk($sformatf("i%0d lit frame cycle %0d", g, k), int'(txd_w[g]), int'(frame[(k-1)/cpb]));
    end
    chk($sformatf("i%0d lit busy last stop cycle", g), int'(busy_w[g]), 1);
    @(negedge clock);
    chk($sformatf("i%0d lit busy after frame", g), int'(busy_w[g]), 0);
    chk($sformatf("i%0d lit txd idle", g), int'(txd_w[g]), 1);
  endtask

  initial begin
    int  acc;
    int  cyc;
    int  rate;
    bit  rdy;
    bit  done;

    repeat (3) @(negedge clock);
    reset    = 1'b0;
    checking = 1'b1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("i%0d reset txd", g),   int'(txd_w[g]),   1);
      chk($sformatf("i%0d reset ready", g), int'(ready_w[g]), 1);
      chk($sformatf("i%0d reset busy", g),  int'(busy_w[g]),  0);
      chk($sformatf("i%0d reset count", g), count_w[g],       0);
    end

    // Hand-derived frames, bit 0 = start bit, transmitted LSB first.
    frame_literal(0, 8'h55, 12'h2AA, 10);   // 8N1: 0,10101010,1
    frame_literal(1, 8'h7F, 12'h6FE, 11);   // 7O2: 0,1111111,0,11
    frame_literal(1, 8'h00, 12'h700, 11);   // 7O2: 0,0000000,1,11
    frame_literal(2, 8'h01, 12'h602, 11);   // 8E1: 0,10000000,1,1

    // Continuous push of 0xA0..0xA5 into the depth-4 instance.
    pulse_reset();
    acc = 0;
    cyc = 0;
    done = 1'b0;
    tx_data_v = 8'hA0;
    tx_valid  = 1'b1;
    for (int c = 0; c < 200 && acc < 6; c++) begin
      rdy = ready_w[0];
      @(negedge clock);
      cyc++;
      if (rdy) begin
        acc++;
        tx_data_v = 8'hA0 + 8'(acc);
        if (acc == 5) begin
          chk("i0 count at full", count_w[0], 4);
          chk("i0 ready at full", int'(ready_w[0]), 0);
        end
      end
    end
    tx_valid = 1'b0;
    chk("i0 pushes accepted", acc, 6);
    for (int c = 0; c < 400 && !done; c++) begin
      if (!busy_w[0]) done = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
    // six 40-cycle frames back to back after a one-cycle start latency
    chk("i0 six-frame span", cyc, 242);

    // Reset in the middle of data bits with entries queued.
    pulse_reset();
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data_v = 8'h11 * 8'(i + 1);
      @(negedge clock);
    end
    tx_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("i%0d midreset txd", g),   int'(txd_w[g]),   1);
      chk($sformatf("i%0d midreset count", g), count_w[g],       0);
      chk($sformatf("i%0d midreset busy", g),  int'(busy_w[g]),  0);
      chk($sformatf("i%0d midreset ready", g), int'(ready_w[g]), 1);
    end
    tx_data_v = 8'h3C;
    tx_valid  = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (80) @(negedge clock);

    // Random traffic with bursty push rates and occasional resets.
    rate = 50;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if (c % 250 == 0) rate = int'($urandom_range(0, 100));
      reset     = ($urandom_range(0, 599) == 0);
      tx_valid  = (int'($urandom_range(0, 99)) < rate);
      tx_data_v = 8'($urandom);
    end
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (1000) @(negedge clock);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("i%0d drained busy", g),  int'(busy_w[g]), 0);
      chk($sformatf("i%0d drained count", g), count_w[g],      0);
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
